interboard_tx: RTL and testbench
================================

# interboard_tx

Serial transmitter for the inter-board link; it is the sending end of the command stream that arrives on the peer board as `interboard_*`. On the active player's board it takes each GameControl command (`ctrl_*`, one-cycle `ctrl_en` pulse), frames it, and shifts it out on a single wire. It then waits for an acknowledge edge from the peer and retransmits on timeout. A one-entry pending buffer absorbs a command issued while a frame is in flight.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles each serial bit is held (≥2).
- `ACK_TIMEOUT`, 4096: cycles to wait in WAIT_ACK before retransmitting.
- `MAX_RETRY`, 3: retransmissions allowed after the first send.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ctrl_en`  in  1  one-cycle command request.
- `ctrl_move_dir`  in  1  0 left, 1 right.
- `ctrl_msg_type`  in  4  message type (0–7 used).
- `ctrl_block_x`  in  5  column 0–17.
- `ctrl_block_y`  in  3  row 0–7.
- `ctrl_card`  in  6  card id 0–54.
- `ctrl_sel_len`  in  3  selection length.
- `ack_in`  in  1  asynchronous acknowledge from peer; rising edge = ack.
- `tx_data`  out  1  serial line; idles high.
- `busy`  out  1  high while the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse: frame acknowledged.
- `fail`  out  1  one-cycle pulse: retries exhausted, command dropped.
- `overflow`  out  1  one-cycle pulse: request dropped, buffer full.

## Operation
- Payload, 22 bits: [0] move_dir, [4:1] msg_type, [9:5] block_x, [12:10] block_y, [18:13] card, [21:19] sel_len.
- Frame, 25 bits, sent in order: start bit (0), payload LSB first, even-parity bit (XOR of the payload), stop bit (1).
- FSM states:
  - IDLE: if the buffer is valid, load the shift register from the buffer and go to SEND. Otherwise a `ctrl_en` loads the shift register directly and goes to SEND.
  - SEND: shift out 25 bits at `CLKS_PER_BIT` cycles each, then go to WAIT_ACK.
  - WAIT_ACK:
    - Ack edge: pulse `done` and go to IDLE.
    - Timer reaches `ACK_TIMEOUT` with retry count < `MAX_RETRY`: increment the count, reload the same frame, go to SEND.
    - Timer reaches `ACK_TIMEOUT` otherwise: pulse `fail` and go to IDLE.
- Retry count clears on every new command.
- `ack_in` passes through a 2-flop synchronizer; an edge is sync2=1 with its previous value 0. Edges outside WAIT_ACK are discarded.
- Buffer:
  - A `ctrl_en` while not in IDLE, or while IDLE is draining the buffer, is written to the buffer if the buffer is empty or is being drained that cycle.
  - Otherwise the request is dropped and `overflow` pulses.
- Unused `msg_type` values are sent unchanged; no filtering.

## Timing
- Reset: `tx_data`=1, `busy`=`done`=`fail`=`overflow`=0; buffer empty; counters 0; synchronizer flops 0.
- `ctrl_en` sampled high at edge N in IDLE: `busy` and `tx_data`=0 from edge N+1.
- The start bit occupies cycles N+1 … N+`CLKS_PER_BIT`; the stop bit ends at N+25·`CLKS_PER_BIT`.
- WAIT_ACK is entered on the next edge; `tx_data` stays 1 there.
- Ack latency: `done` is high exactly 3 cycles after the first edge at which `ack_in` samples 1. `busy` falls in the same cycle `done` is high.
- On timeout the retransmitted start bit begins the cycle after the timer expires.
- If the buffer is valid when `done` or `fail` pulses, the buffered frame's start bit begins 2 cycles after that pulse (one IDLE cycle).
- `rst` mid-frame: the next edge forces `tx_data`=1 and IDLE. The frame is abandoned and the buffer is cleared; no `done` or `fail` is issued.
- `rst` and `ctrl_en` in the same cycle: reset wins and the request is lost.
- The timer width must hold `ACK_TIMEOUT`; the bit counter counts 0–24; the divider counts 0 to `CLKS_PER_BIT`−1.

## Test plan
Parameters for all scenarios: `CLKS_PER_BIT`=4, `ACK_TIMEOUT`=64, `MAX_RETRY`=2.
- Single frame: send msg_type=1, x=17, y=7, card=53, sel_len=0, dir=0 → payload 0x06BE22, parity 0. The line is low for 4 cycles from N+1, the 100-cycle frame matches bit for bit, and the line ends high.
- Ack: raise `ack_in` 10 cycles into WAIT_ACK → `done` is high for exactly 1 cycle, 3 cycles later; `busy` drops in that same cycle.
- No ack → 3 identical frames, each started 64 cycles after the previous stop bit, then `fail` pulses once and `busy`=0.
- Back-to-back: send A, then B and C during A's frame → B is buffered and C raises `overflow`. After A's `done`, B's start bit begins 2 cycles later.
- Spurious ack: toggle `ack_in` during SEND → ignored; a later ack in WAIT_ACK still yields exactly one `done`.
- Reset at bit 10 with B buffered → `tx_data`=1 next cycle, `busy`=0, and no frame follows.

Source files
------------

// File: rtl/interboard_tx.sv
// -----------------------------------------------------------------------------
// interboard_tx
//
// Sending end of the inter-board command link. Each GameControl command
// (one-cycle ctrl_en pulse) is packed into a 22-bit payload and framed as
// start(0), payload LSB first, even parity, stop(1). That is 25 bits, each held
// for CLKS_PER_BIT cycles on tx_data. After the stop bit the block waits for
// a rising edge on ack_in. It retransmits the same frame on timeout, up to
// MAX_RETRY times. A one-entry buffer holds a command that arrives while a
// frame is in flight.
//
// Parameters:
//   CLKS_PER_BIT  cycles each serial bit is held (>= 2)
//   ACK_TIMEOUT   cycles spent in WAIT_ACK before a retransmission
//   MAX_RETRY     retransmissions allowed after the first send
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   ctrl_en        one-cycle command request
//   ctrl_move_dir  0 left, 1 right
//   ctrl_msg_type  message type (sent unchanged)
//   ctrl_block_x   column
//   ctrl_block_y   row
//   ctrl_card      card id
//   ctrl_sel_len   selection length
//   ack_in         asynchronous acknowledge from peer, rising edge = ack
//   tx_data        serial line, idles high
//   busy           high while not IDLE
//   done           one-cycle pulse, frame acknowledged
//   fail           one-cycle pulse, retries exhausted, command dropped
//   overflow       one-cycle pulse, request dropped because buffer full
// -----------------------------------------------------------------------------
module interboard_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ACK_TIMEOUT  = 4096,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en,
  input  logic       ctrl_move_dir,
  input  logic [3:0] ctrl_msg_type,
  input  logic [4:0] ctrl_block_x,
  input  logic [2:0] ctrl_block_y,
  input  logic [5:0] ctrl_card,
  input  logic [2:0] ctrl_sel_len,
  input  logic       ack_in,
  output logic       tx_data,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       overflow
);

  localparam int FRAME_BITS = 25;
  localparam int DIV_W      = $clog2(CLKS_PER_BIT);
  localparam int TMR_W      = $clog2(ACK_TIMEOUT + 1);
  localparam int RTY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK
  } state_t;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [FRAME_BITS-1:0]   buf_q, buf_d;
  logic                    buf_valid_q, buf_valid_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [4:0]              bit_q, bit_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [TMR_W-1:0]        timer_inc;
  logic [RTY_W-1:0]        retry_q, retry_d;
  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic                    overflow_q, overflow_d;
  logic                    sync1_q, sync2_q, sync_prev_q;

  logic [21:0]             payload;
  logic [FRAME_BITS-1:0]   new_frame;
  logic                    ack_edge;
  logic                    drain;

  // Pack the incoming command and wrap it in start, parity and stop bits.
  // Bit 0 of the frame goes out first, so the start bit sits at the bottom.
  always_comb begin
    payload   = {ctrl_sel_len, ctrl_card, ctrl_block_y, ctrl_block_x,
                 ctrl_msg_type, ctrl_move_dir};
    new_frame = {1'b1, ^payload, payload, 1'b0};
  end

  // A drain is held off while done/fail is still high. This leaves one quiet
  // IDLE cycle on the line between an acknowledged or failed frame and the
  // buffered one.
  assign ack_edge  = sync2_q & ~sync_prev_q;
  assign drain     = (state_q == IDLE) && buf_valid_q && !(done_q || fail_q);
  assign timer_inc = timer_q + TMR_W'(1);

  // Next-state and datapath logic for the framing FSM, followed by the
  // buffer bookkeeping for requests that cannot start immediately.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    frame_d     = frame_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    div_d       = div_q;
    bit_d       = bit_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    overflow_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (drain) begin
          shift_d     = buf_q;
          frame_d     = buf_q;
          buf_valid_d = 1'b0;
          div_d       = '0;
          bit_d       = '0;
          retry_d     = '0;
          state_d     = SEND;
        end else if (ctrl_en && !buf_valid_q) begin
          shift_d = new_frame;
          frame_d = new_frame;
          div_d   = '0;
          bit_d   = '0;
          retry_d = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (div_q == DIV_W'(CLKS_PER_BIT - 1)) begin
          div_d = '0;
          if (bit_q == 5'(FRAME_BITS - 1)) begin
            timer_d = '0;
            state_d = WAIT_ACK;
          end else begin
            bit_d   = bit_q + 5'd1;
            shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      WAIT_ACK: begin
        if (ack_edge) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timer_inc == TMR_W'(ACK_TIMEOUT)) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            shift_d = frame_q;
            div_d   = '0;
            bit_d   = '0;
            state_d = SEND;
          end else begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_inc;
        end
      end

      default: state_d = IDLE;
    endcase

    // A request that does not start directly from IDLE goes to the buffer.
    // It is accepted when the buffer is empty or is being drained this cycle,
    // and dropped otherwise.
    if (ctrl_en && !((state_q == IDLE) && !buf_valid_q)) begin
      if (!buf_valid_q || drain) begin
        buf_d       = new_frame;
        buf_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State register, plus the ack synchronizer and the edge-history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '1;
      frame_q     <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      overflow_q  <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      frame_q     <= frame_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      overflow_q  <= overflow_d;
      sync1_q     <= ack_in;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  // The line sits high everywhere except while a frame is being shifted.
  assign tx_data  = (state_q == SEND) ? shift_q[0] : 1'b1;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign fail     = fail_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_interboard_tx.sv
// -----------------------------------------------------------------------------
// tb_interboard_tx
//
// Directed bench for interboard_tx with CLKS_PER_BIT=4, ACK_TIMEOUT=64 and
// MAX_RETRY=2. Inputs change on the falling edge and outputs are sampled on
// the falling edge. The k-th falling edge after the edge that accepts a command
// therefore shows the line as it is during cycle N+k.
// -----------------------------------------------------------------------------
module tb_interboard_tx;

  localparam int CPB = 4;
  localparam int TMO = 64;
  localparam int RTY = 2;

  // Hand-packed frames {stop, parity, payload, start}.
  // A: dir0 msg1 x17 y7 card53 sel0 -> payload 0x06BE22, parity 0
  // B: dir1 msg3 x5  y2 card10 sel4 -> payload 0x2148A7, parity 1
  // D: dir1 msg12 (unused type), rest 0 -> payload 0x000019, parity 1
  localparam logic [24:0] FRAME_A = {1'b1, 1'b0, 22'h06BE22, 1'b0};
  localparam logic [24:0] FRAME_B = {1'b1, 1'b1, 22'h2148A7, 1'b0};
  localparam logic [24:0] FRAME_D = {1'b1, 1'b1, 22'h000019, 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic       ctrl_en;
  logic       ctrl_move_dir;
  logic [3:0] ctrl_msg_type;
  logic [4:0] ctrl_block_x;
  logic [2:0] ctrl_block_y;
  logic [5:0] ctrl_card;
  logic [2:0] ctrl_sel_len;
  logic       ack_in;
  logic       tx_data;
  logic       busy;
  logic       done;
  logic       fail;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  interboard_tx #(
    .CLKS_PER_BIT(CPB),
    .ACK_TIMEOUT (TMO),
    .MAX_RETRY   (RTY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_en      (ctrl_en),
    .ctrl_move_dir(ctrl_move_dir),
    .ctrl_msg_type(ctrl_msg_type),
    .ctrl_block_x (ctrl_block_x),
    .ctrl_block_y (ctrl_block_y),
    .ctrl_card    (ctrl_card),
    .ctrl_sel_len (ctrl_sel_len),
    .ack_in       (ack_in),
    .tx_data      (tx_data),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Every frame bit stretched over CPB consecutive line samples.
  function automatic logic [99:0] expandFrame(input logic [24:0] f);
    logic [99:0] r;
    for (int i = 0; i < 100; i++) r[i] = f[i / CPB];
    return r;
  endfunction

  // Presents a command, holds ctrl_en across one rising edge, then drops it.
  task automatic applyStimulus(input logic dir, input logic [3:0] msg,
                               input logic [4:0] bx, input logic [2:0] by,
                               input logic [5:0] cd, input logic [2:0] sl);
    ctrl_move_dir = dir;
    ctrl_msg_type = msg;
    ctrl_block_x  = bx;
    ctrl_block_y  = by;
    ctrl_card     = cd;
    ctrl_sel_len  = sl;
    ctrl_en       = 1'b1;
    @(posedge clk);
    #1 ctrl_en = 1'b0;
  endtask

  // Records 100 line samples and counts samples where busy was low.
  task automatic captureLine(output logic [99:0] obs, output int busyLow);
    busyLow = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      obs[i] = tx_data;
      if (busy !== 1'b1) busyLow++;
    end
  endtask

  // Counts samples over n cycles where the line is not quiet: tx not high,
  // busy not as given, or a stray done/fail pulse.
  task automatic watchLine(input int n, input logic expBusy, output int errs);
    errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_data !== 1'b1 || busy !== expBusy || done !== 1'b0 || fail !== 1'b0)
        errs++;
    end
  endtask

  task automatic test_reset();
    int errs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({tx_data, busy, done, fail, overflow} !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b want 10000",
               {tx_data, busy, done, fail, overflow});
    end
    rst = 1'b0;
    watchLine(10, 1'b0, errs);
    total++;
    if (errs !== 0) begin
      bad++;
      $display("[TB] FAIL reset_idle: got %0d noisy cycles want 0", errs);
    end
  endtask

  task automatic test_single_frame();
    logic [99:0] obs;
    int          busyLow;
    applyStimulus(1'b0, 4'd1, 5'd17, 3'd7, 6'd53, 3'd0);
    captureLine(obs, busyLow);
    total++;
    if (obs !== expandFrame(FRAME_A)) begin
      bad++;
      $display("[TB] FAIL single_frame: got %h want %h", obs, expandFrame(FRAME_A));
    end
    total++;
    if (busyLow !== 0) begin
      bad++;
      $display("[TB] FAIL single_busy: got %0d low cycles want 0", busyLow);
    end
    @(negedge clk);
    total++;
    if ({tx_data, busy} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL single_wait_line: got %b want 11", {tx_data, busy});
    end
    ack_in = 1'b1;
    repeat (8) @(negedge clk);
    ack_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ack();
    logic [7:0] doneSeen;
    logic [7:0] busySeen;
    applyStimulus(1'b0, 4'd1, 5'd17, 3'd7, 6'd53, 3'd0);
    repeat (110) @(negedge clk);
    ack_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      doneSeen[k] = done;
      busySeen[k] = busy;
    end
    ack_in = 1'b0;
    total++;
    if (doneSeen !== 8'b0000_0100) begin
      bad++;
      $display("[TB] FAIL ack_done: got %b want 00000100", doneSeen);
    end
    total++;
    if (busySeen !== 8'b0000_0011) begin
      bad++;
      $display("[TB] FAIL ack_busy: got %b want 00000011", busySeen);
    end
  endtask

  task automatic test_timeout();
    logic [99:0] obs;
    int          busyLow;
    int          errs;
    applyStimulus(1'b0, 4'd1, 5'd17, 3'd7, 6'd53, 3'd0);
    for (int f = 0; f < 3; f++) begin
      captureLine(obs, busyLow);
      total++;
      if (obs !== expandFrame(FRAME_A) || busyLow !== 0) begin
        bad++;
        $display("[TB] FAIL timeout_frame%0d: got %h want %h", f, obs,
                 expandFrame(FRAME_A));
      end
      watchLine(TMO, 1'b1, errs);
      total++;
      if (errs !== 0) begin
        bad++;
        $display("[TB] FAIL timeout_gap%0d: got %0d noisy cycles want 0", f, errs);
      end
    end
    @(negedge clk);
    total++;
    if ({fail, busy, tx_data} !== 3'b101) begin
      bad++;
      $display("[TB] FAIL timeout_fail: got %b want 101", {fail, busy, tx_data});
    end
    watchLine(20, 1'b0, errs);
    total++;
    if (errs !== 0) begin
      bad++;
      $display("[TB] FAIL timeout_after: got %0d noisy cycles want 0", errs);
    end
  endtask

  task automatic test_back_to_back();
    logic [99:0] obs;
    int          busyLow;
    int          doneCnt;
    int          errs;
    logic [3:0]  doneSeen;
    logic [3:0]  busySeen;
    logic [3:0]  txSeen;
    applyStimulus(1'b0, 4'd1, 5'd17, 3'd7, 6'd53, 3'd0);
    repeat (10) @(negedge clk);
    applyStimulus(1'b1, 4'd3, 5'd5, 3'd2, 6'd10, 3'd4);
    @(negedge clk);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_buffer_b: got overflow=%b want 0", overflow);
    end
    applyStimulus(1'b0, 4'd0, 5'd0, 3'd0, 6'd1, 3'd0);
    @(negedge clk);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_overflow_c: got overflow=%b want 1", overflow);
    end
    repeat (98) @(negedge clk);
    ack_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      doneSeen[k] = done;
      busySeen[k] = busy;
      txSeen[k]   = tx_data;
    end
    ack_in = 1'b0;
    total++;
    if (doneSeen !== 4'b0100 || busySeen !== 4'b0011 || txSeen !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL b2b_gap: got done=%b busy=%b tx=%b want 0100 0011 1111",
               doneSeen, busySeen, txSeen);
    end
    captureLine(obs, busyLow);
    total++;
    if (obs !== expandFrame(FRAME_B) || busyLow !== 0) begin
      bad++;
      $display("[TB] FAIL b2b_frame_b: got %h want %h", obs, expandFrame(FRAME_B));
    end
    repeat (2) @(negedge clk);
    ack_in  = 1'b1;
    doneCnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    ack_in = 1'b0;
    total++;
    if (doneCnt !== 1) begin
      bad++;
      $display("[TB] FAIL b2b_done_b: got %0d pulses want 1", doneCnt);
    end
    watchLine(30, 1'b0, errs);
    total++;
    if (errs !== 0) begin
      bad++;
      $display("[TB] FAIL b2b_after: got %0d noisy cycles want 0", errs);
    end
  endtask

  task automatic test_spurious_ack();
    logic [99:0] obs;
    int          busyLow;
    int          doneCnt;
    applyStimulus(1'b1, 4'd12, 5'd0, 3'd0, 6'd0, 3'd0);
    doneCnt = 0;
    busyLow = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      obs[i] = tx_data;
      if (busy !== 1'b1) busyLow++;
      if (done === 1'b1) doneCnt++;
      if (i == 20 || i == 60) ack_in = 1'b1;
      if (i == 40 || i == 70) ack_in = 1'b0;
    end
    total++;
    if (obs !== expandFrame(FRAME_D) || busyLow !== 0 || doneCnt !== 0) begin
      bad++;
      $display("[TB] FAIL spurious_frame: got %h busyLow=%0d done=%0d want %h 0 0",
               obs, busyLow, doneCnt, expandFrame(FRAME_D));
    end
    repeat (5) @(negedge clk);
    ack_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    ack_in = 1'b0;
    total++;
    if (doneCnt !== 1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL spurious_done: got %0d pulses busy=%b want 1 0",
               doneCnt, busy);
    end
  endtask

  task automatic test_reset_midframe();
    int errs;
    applyStimulus(1'b0, 4'd1, 5'd17, 3'd7, 6'd53, 3'd0);
    repeat (5) @(negedge clk);
    applyStimulus(1'b1, 4'd3, 5'd5, 3'd2, 6'd10, 3'd4);
    repeat (37) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({tx_data, busy, done, fail} !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL midreset_line: got %b want 1000",
               {tx_data, busy, done, fail});
    end
    watchLine(200, 1'b0, errs);
    total++;
    if (errs !== 0) begin
      bad++;
      $display("[TB] FAIL midreset_quiet: got %0d noisy cycles want 0", errs);
    end
  endtask

  task automatic test_reset_wins();
    int errs;
    rst = 1'b1;
    applyStimulus(1'b0, 4'd1, 5'd17, 3'd7, 6'd53, 3'd0);
    rst = 1'b0;
    watchLine(40, 1'b0, errs);
    total++;
    if (errs !== 0) begin
      bad++;
      $display("[TB] FAIL reset_wins: got %0d noisy cycles want 0", errs);
    end
  endtask

  // Runs every scenario in order and prints the summary line.
  initial begin
    rst           = 1'b1;
    ctrl_en       = 1'b0;
    ctrl_move_dir = 1'b0;
    ctrl_msg_type = 4'd0;
    ctrl_block_x  = 5'd0;
    ctrl_block_y  = 3'd0;
    ctrl_card     = 6'd0;
    ctrl_sel_len  = 3'd0;
    ack_in        = 1'b0;
    test_reset();
    test_single_frame();
    test_ack();
    test_timeout();
    test_back_to_back();
    test_spurious_ack();
    test_reset_midframe();
    test_reset_wins();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
